univ_shift_reg: RTL
===================

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter W, default 8, register width in bits; legal values 2..64.
REQ-002 Parameter CNT_W, default $clog2(W)+1, width of the step-count input.
REQ-003 clk  in  1  sole clock; all state updates on posedge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 ld  in  1  parallel load request.
REQ-006 d  in  W  parallel load data.
REQ-007 sh  in  1  single-step shift request.
REQ-008 start  in  1  multi-step shift request.
REQ-009 amt  in  CNT_W  step count for start.
REQ-010 op  in  3  shift operation: 000 SHR, 001 SHL, 010 ASR, 011 ROR, 100 ROL; 101..111 reserved (NOP).
REQ-011 sh_in  in  1  serial fill bit: MSB for SHR, LSB for SHL.
REQ-012 q  out  W  register contents.
REQ-013 sh_out  out  1  bit discarded or rotated by the most recent step.
REQ-014 busy  out  1  multi-step sequence in progress.
REQ-015 done  out  1  one-cycle pulse when a sequence completes.

Function
REQ-016 Step definitions: SHR q<={sh_in,q[W-1:1]}, sh_out<=q[0]; SHL q<={q[W-2:0],sh_in}, sh_out<=q[W-1]; ASR q<={q[W-1],q[W-1:1]}, sh_out<=q[0]; ROR q<={q[0],q[W-1:1]}, sh_out<=q[0]; ROL q<={q[W-2:0],q[W-1]}, sh_out<=q[W-1].
REQ-017 Reserved op codes leave q and sh_out unchanged, but each still counts as one step.
REQ-018 FSM states: IDLE and RUN.
REQ-019 IDLE priority at each edge: ld > start > sh > hold.
REQ-020 IDLE, ld=1: q<=d; sh_out unchanged.
REQ-021 IDLE, start=1, amt=0: q unchanged; done=1 for one cycle; busy stays 0; FSM stays IDLE.
REQ-022 IDLE, start=1, amt=k>0: latch op and k; busy<=1; enter RUN; q is not changed at this edge.
REQ-023 RUN: each edge performs one step of the latched op using the current sh_in, then decrements the count.
REQ-024 On the edge that performs the final step, busy<=0 and done<=1, and the FSM returns to IDLE. An amt=k sequence therefore shifts on edges T1..Tk after start is sampled at T0, with done high in the cycle after Tk.
REQ-025 IDLE, sh=1 (no ld/start): perform one step of the live op; busy and done are unaffected.
REQ-026 In RUN, ld, sh, start and op changes are ignored.
REQ-027 done is low in every cycle other than those in REQ-021 and REQ-024.
REQ-028 amt values above W are legal and execute exactly amt steps; there is no saturation.

Reset
REQ-029 rst=1 at an edge: q<=0, sh_out<=0, busy<=0, done<=0, FSM<=IDLE, count<=0; this takes priority over all other inputs.
REQ-030 Reset during RUN aborts the sequence without asserting done.

Configuration
REQ-031 With macro USR_ROTATE_EN defined, ROR and ROL behave as in REQ-016.
REQ-032 Without USR_ROTATE_EN, op codes 011 and 100 are treated as reserved (REQ-017), and no rotate logic is synthesised.

Structure
REQ-033 Package usr_pkg holds the op-code enum (OP_SHR..OP_ROL), the FSM state enum, and the function computing CNT_W.
REQ-034 One sub-module, usr_step (combinational, parametrised W), computes the next q and sh_out for a given op, q and sh_in; it is shared by the sh path and the RUN path.

Verification
REQ-035 W=8: rst=1 for one edge with ld=1, d=8'hFF -> q=00, busy=0, done=0, sh_out=0.
REQ-036 W=8: ld with d=8'hA5, then start with op=SHL, amt=3, sh_in=1 -> busy high for 3 cycles; q=2F; sh_out=1; done pulses once.
REQ-037 W=8: q=8'h81, start with op=ASR, amt=2 -> q=E0, sh_out=0.
REQ-038 W=8: q=8'h81, start with op=ROR, amt=9, USR_ROTATE_EN defined -> q=C0, sh_out=1; with the macro undefined -> q=81.
REQ-039 W=8: start with amt=0 -> done=1 in the next cycle, busy never asserts, q unchanged; ld and start asserted together -> the load wins and no sequence starts.
REQ-040 W=8: start with amt=5, then rst asserted after the 2nd shift -> q=00 and busy=0 on the next cycle, and done is never asserted; also, ld pulsed during RUN -> q unaffected.

Source files
------------

// File: rtl/usr_pkg.sv
// usr_pkg: op codes, FSM states and step-count width helper for univ_shift_reg.
package usr_pkg;
    typedef enum logic [2:0] {
        OP_SHR = 3'd0,
        OP_SHL = 3'd1,
        OP_ASR = 3'd2,
        OP_ROR = 3'd3,
        OP_ROL = 3'd4
    } op_t;
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction
endpackage

// File: rtl/usr_step.sv
// usr_step: one combinational shift/rotate step; act is low for ops that leave q and sh_out alone.
// Rotates exist only when USR_ROTATE_EN is defined.
module usr_step
    import usr_pkg::*;
#(
    parameter int W = 8
) (
    input  logic [2:0]   op,
    input  logic [W-1:0] q,
    input  logic         sh_in,
    output logic [W-1:0] q_nxt,
    output logic         sh_out,
    output logic         act
);
    always_comb begin
        q_nxt  = q;
        sh_out = 1'b0;
        act    = 1'b1;
        case (op)
            OP_SHR: begin
                q_nxt  = {sh_in, q[W-1:1]};
                sh_out = q[0];
            end
            OP_SHL: begin
                q_nxt  = {q[W-2:0], sh_in};
                sh_out = q[W-1];
            end
            OP_ASR: begin
                q_nxt  = {q[W-1], q[W-1:1]};
                sh_out = q[0];
            end
`ifdef USR_ROTATE_EN
            OP_ROR: begin
                q_nxt  = {q[0], q[W-1:1]};
                sh_out = q[0];
            end
            OP_ROL: begin
                q_nxt  = {q[W-2:0], q[W-1]};
                sh_out = q[W-1];
            end
`endif
            default: act = 1'b0;
        endcase
    end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: universal shift register with parallel load, single steps and counted multi-step runs.
// Define USR_ROTATE_EN to enable ROR/ROL; otherwise those op codes are reserved no-ops.
module univ_shift_reg
    import usr_pkg::*;
#(
    parameter int W     = 8,
    parameter int CNT_W = cnt_width(W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [W-1:0]     d,
    input  logic             sh,
    input  logic             start,
    input  logic [CNT_W-1:0] amt,
    input  logic [2:0]       op,
    input  logic             sh_in,
    output logic [W-1:0]     q,
    output logic             sh_out,
    output logic             busy,
    output logic             done
);
    state_t             state, state_nxt;
    logic [2:0]         op_r, op_d, step_op;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [W-1:0]       q_d, step_q;
    logic               so_d, done_d, step_so, step_act, last;

    assign last    = cnt == CNT_W'(1);
    assign step_op = state == RUN ? op_r : op;
    assign busy    = state == RUN;

    usr_step #(.W(W)) u_step (
        .op    (step_op),
        .q     (q),
        .sh_in (sh_in),
        .q_nxt (step_q),
        .sh_out(step_so),
        .act   (step_act)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q      <= '0;
            sh_out <= 1'b0;
            done   <= 1'b0;
            cnt    <= '0;
            op_r   <= '0;
        end else begin
            state  <= state_nxt;
            q      <= q_d;
            sh_out <= so_d;
            done   <= done_d;
            cnt    <= cnt_d;
            op_r   <= op_d;
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == IDLE)
            state_nxt = (!ld && start && amt != '0) ? RUN : IDLE;
        else
            state_nxt = last ? IDLE : RUN;
    end

    // In RUN every edge consumes one count even when the latched op is a no-op.
    always_comb begin
        q_d    = q;
        so_d   = sh_out;
        cnt_d  = cnt;
        op_d   = op_r;
        done_d = 1'b0;
        if (state == RUN) begin
            q_d    = step_act ? step_q : q;
            so_d   = step_act ? step_so : sh_out;
            cnt_d  = cnt - CNT_W'(1);
            done_d = last;
        end else if (ld) begin
            q_d = d;
        end else if (start) begin
            op_d   = op;
            cnt_d  = amt;
            done_d = amt == '0;
        end else if (sh) begin
            q_d  = step_act ? step_q : q;
            so_d = step_act ? step_so : sh_out;
        end
    end
endmodule
